// File: rtl/seq_detect_prog_if.sv
// Configuration, sample stream and status bundle of the programmable serial pattern detector.
interface seq_detect_prog_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic               ena;
   logic               input_bit;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               clr_count;
   logic               output_indicator;
   logic [CNT_W-1:0]   match_count;
   logic [LEN_W-1:0]   fill;
   logic               cfg_err;

   modport master (
      output ena, input_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
      input  output_indicator, match_count, fill, cfg_err
   );

   modport slave (
      input  ena, input_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
      output output_indicator, match_count, fill, cfg_err
   );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector: matches the last len sampled bits against a
// loaded pattern, with overlap control and a saturating match counter.
module seq_detect_prog #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   seq_detect_prog_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(5'b10101);
   localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(5);
   localparam logic [LEN_W-1:0]   MAX_LEN_L   = LEN_W'(MAX_LEN);

   // Only MAX_LEN-1 past bits are stored; the newest bit comes straight from input_bit.
   logic [MAX_LEN-2:0] hist_q;
   logic [MAX_LEN-1:0] hist_d;
   logic [MAX_LEN-1:0] pattern_q;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   fill_d;
   logic [CNT_W-1:0]   count_q;
   logic               overlap_q;
   logic               ind_q;
   logic               err_q;
   logic               match_d;
   logic               cfg_ok;
   logic               sample;

   // NOTE: every signal written here is assigned on every path, so no latch is inferred.
   always_comb begin
      hist_d   = {hist_q, bus.input_bit};
      fill_d   = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
      len_mask = ~({MAX_LEN{1'b1}} << len_q);
      match_d  = (fill_d == len_q) && (((hist_d ^ pattern_q) & len_mask) == '0);
      cfg_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);
      sample   = bus.ena && !bus.cfg_load;
   end

   // NOTE: non-blocking assignments keep every register update based on pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q    <= '0;
         pattern_q <= RST_PATTERN;
         len_q     <= RST_LEN;
         overlap_q <= 1'b1;
         fill_q    <= '0;
         ind_q     <= 1'b0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         ind_q <= 1'b0;
         if (bus.cfg_load) begin
            hist_q <= '0;
            fill_q <= '0;
            if (cfg_ok) begin
               pattern_q <= bus.cfg_pattern;
               len_q     <= bus.cfg_len;
               overlap_q <= bus.cfg_overlap;
               err_q     <= 1'b0;
            end else begin
               err_q <= 1'b1;
            end
         end else if (bus.ena) begin
            hist_q <= hist_d[MAX_LEN-2:0];
            fill_q <= (match_d && !overlap_q) ? '0 : fill_d;
            ind_q  <= match_d;
         end

         if (bus.clr_count) begin
            count_q <= '0;
         end else if (sample && match_d && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   assign bus.output_indicator = ind_q;
   assign bus.match_count      = count_q;
   assign bus.fill             = fill_q;
   assign bus.cfg_err          = err_q;
endmodule
